// File: rtl/cskip_pkg.sv
// Shared constants and operand types for the carry-skip add/subtract family.
package cskip_pkg;

    localparam int CSKIP_WIDTH = 16;
    localparam int CSKIP_BLK   = 4;
    localparam int CSKIP_HALF  = CSKIP_WIDTH / 2;

    typedef logic [CSKIP_WIDTH-1:0] word_t;
    typedef logic [CSKIP_HALF-1:0]  half_t;

endpackage

// File: rtl/cskip_sub_blk.sv
// One carry-skip block of a + ~b: BLK-bit ripple with a bypass mux when every bit propagates.
module cskip_sub_blk
    import cskip_pkg::*;
#(
    parameter int BLK = CSKIP_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] diff,
    output logic           cout
);

    logic [BLK-1:0] bn;
    logic [BLK:0]   c;
    logic           p;

    assign bn = ~b;

    always_comb begin
        c    = '0;
        diff = '0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            diff[i]  = a[i] ^ bn[i] ^ c[i];
            c[i+1]   = (a[i] & bn[i]) | ((a[i] ^ bn[i]) & c[i]);
        end
    end

    // When the whole block propagates, its carry-out equals its carry-in.
    assign p    = &(a ^ bn);
    assign cout = p ? cin : c[BLK];

endmodule

// File: rtl/cskip_sub16_pipe.sv
// Two-stage pipelined carry-skip subtractor (diff = a + ~b + 1) with valid/ready on both sides.
// Optional macro CSKIP_SUB_SAT_EN clamps diff to 0 whenever the subtraction borrows.
module cskip_sub16_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH = CSKIP_WIDTH,
    parameter int BLK   = CSKIP_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NB   = HALF / BLK;

    // Handshake: a beat moves when valid & ready are both high at the rising edge; a stage
    // may take new data when it is empty or its content leaves on the same edge.
    logic s1_adv, s2_adv;

    logic            s1_valid;
    logic [HALF-1:0] s1_a_hi, s1_b_hi, s1_d_lo;
    logic            s1_c8;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_diff;
    logic             s2_borrow, s2_ovf;

    logic [HALF-1:0]  lo_d, hi_d;
    logic             c8, c16;
    logic [WIDTH-1:0] full_d, res_d;
    logic             res_borrow, res_ovf;

    assign s2_adv   = !s2_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;

    for (genvar g = 0; g < NB; g++) begin : g_lo
        logic           ci, co;
        logic [BLK-1:0] d;
        if (g == 0) begin : g_first
            assign ci = 1'b1;
        end else begin : g_chain
            assign ci = g_lo[g-1].co;
        end
        cskip_sub_blk #(.BLK(BLK)) u_blk (
            .a    (a[g*BLK +: BLK]),
            .b    (b[g*BLK +: BLK]),
            .cin  (ci),
            .diff (d),
            .cout (co)
        );
        assign lo_d[g*BLK +: BLK] = d;
    end
    assign c8 = g_lo[NB-1].co;

    for (genvar g = 0; g < NB; g++) begin : g_hi
        logic           ci, co;
        logic [BLK-1:0] d;
        if (g == 0) begin : g_first
            assign ci = s1_c8;
        end else begin : g_chain
            assign ci = g_hi[g-1].co;
        end
        cskip_sub_blk #(.BLK(BLK)) u_blk (
            .a    (s1_a_hi[g*BLK +: BLK]),
            .b    (s1_b_hi[g*BLK +: BLK]),
            .cin  (ci),
            .diff (d),
            .cout (co)
        );
        assign hi_d[g*BLK +: BLK] = d;
    end
    assign c16 = g_hi[NB-1].co;

    assign full_d     = {hi_d, s1_d_lo};
    assign res_borrow = ~c16;
    assign res_ovf    = (s1_a_hi[HALF-1] ^ s1_b_hi[HALF-1]) & (s1_a_hi[HALF-1] ^ hi_d[HALF-1]);

`ifdef CSKIP_SUB_SAT_EN
    assign res_d = res_borrow ? '0 : full_d;
`else
    assign res_d = full_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
            s1_d_lo  <= '0;
            s1_c8    <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s1_adv && in_valid) begin
                s1_a_hi <= a[WIDTH-1:HALF];
                s1_b_hi <= b[WIDTH-1:HALF];
                s1_d_lo <= lo_d;
                s1_c8   <= c8;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
            s2_ovf    <= 1'b0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                s2_diff   <= res_d;
                s2_borrow <= res_borrow;
                s2_ovf    <= res_ovf;
            end
        end
    end

    assign out_valid = s2_valid;
    assign diff      = s2_diff;
    assign borrow    = s2_borrow;
    assign ovf       = s2_ovf;

endmodule

// File: doc/cskip_sub16_pipe.md
Name: cskip_sub16_pipe

Overview:
Pipelined 16-bit carry-skip subtractor; computes diff = a - b as a + ~b + 1 using 4-bit skip blocks.
Two register stages: stage 1 resolves bits [7:0] and the mid-word carry; stage 2 resolves bits [15:8] and the flags.
Valid/ready handshake on both sides; full backpressure; throughput 1 op/cycle.
Sits beside the 16-bit carry-skip adder in the arithmetic library as its subtract-direction, streaming counterpart.

Parameters:
WIDTH, 16, operand width; must equal 2*HALF.
BLK, 4, skip-block width; HALF must be a multiple of BLK.
HALF, WIDTH/2, bits resolved per pipeline stage (derived, not overridable).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
diff  out  WIDTH  a - b modulo 2^WIDTH
borrow  out  1  1 when unsigned a < b (inverted final carry)
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, all data registers 0; out_valid=0, diff=0, borrow=0, ovf=0. in_ready is combinational and reads 1 during reset.
- Input handshake: transfer when in_valid & in_ready.
- Output handshake: transfer when out_valid & out_ready.
- Stage 1 ready: s1_adv = !s1_valid | s2_adv.
- Stage 2 ready: s2_adv = !s2_valid | out_ready.
- in_ready = s1_adv.
- Stage 1 capture: a[15:8], b[15:8], diff[7:0], and carry c8 from the low half with carry-in = 1.
- Stage 2 capture: diff[15:8] computed from the stored upper operands and c8.
- Flags: borrow = ~c16; ovf = (a[15] ^ b[15]) & (a[15] ^ diff[15]).
- Latency: operands accepted at edge k give out_valid=1 after edge k+1, provided stage 2 was free.
- Stall: while out_valid=1 and out_ready=0, diff, borrow and ovf hold stable.
- Throughput: with both stages full, in_ready=0. No data is lost or duplicated.
- Simultaneous accept and emit in one cycle is legal; both stages advance on the same edge.
- Carry-skip rule per block:
  - p = &(a_i ^ ~b_i).
  - Carry-out = p ? block carry-in : ripple carry-out.
  - Worst case (all blocks propagate) must equal ripple results bit-exactly.
- Reset mid-operation flushes both stages. No result is emitted for in-flight operands.
- Data registers update only on stage advance; valid bits update every edge.
- Holding in_valid high with changing operands while in_ready=0 has no effect.

Optional Feature:
- Macro: CSKIP_SUB_SAT_EN.
- Defined: unsigned saturating mode. When borrow=1, diff is forced to 0; borrow still reports 1; ovf unchanged. The clamp is applied in stage 2 with no added latency.
- Undefined: diff is plain modulo-2^WIDTH; the clamp logic is absent.

Decomposition:
- Package cskip_pkg:
  - localparams CSKIP_WIDTH=16, CSKIP_BLK=4, CSKIP_HALF=8.
  - typedef word_t (WIDTH bits) and half_t (HALF bits).
  - Shared with the adder family.
- Sub-module cskip_sub_blk:
  - BLK-bit ripple of a + ~b plus skip mux.
  - Ports: a, b, cin, diff, cout.
  - Instantiated HALF/BLK times per stage and chained.

Test Plan:
- a=0x1234, b=0x0234, out_ready=1 -> two edges later diff=0x1000, borrow=0, ovf=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0. With CSKIP_SUB_SAT_EN: diff=0x0000, borrow=1.
- Overflow cases:
  - a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
  - a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
- Full skip path: a=0xFFFF, b=0xFFFF, then a=0xA5A5, b=0xA5A5 -> diff=0x0000, borrow=0, ovf=0. Cross-check vs behavioral a-b over 10k random vectors.
- Backpressure:
  - Push 3 ops (1-2, 5-3, 9-4) with out_ready=0; in_ready drops after 2 accepts; diff holds 0xFFFF.
  - Release out_ready -> results 0xFFFF, 0x0002, 0x0005 in order, one per cycle.
- Reset mid-flight: assert rst_n=0 with both stages valid -> out_valid=0 and diff=0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.
